// File: rtl/retire_stage_pkg.sv
// Shared types and sizing for the in-order retire stage and its architectural map table.
package retire_stage_pkg;

    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int XLEN      = 32;
    localparam int TW        = $clog2(PHYS_REGS);
    localparam int AW        = $clog2(ARCH_REGS);

    typedef logic [TW-1:0] tag_t;
    typedef logic [AW-1:0] arch_idx_t;

    // Everything the ROB head presents to retire in one cycle.
    typedef struct packed {
        logic            retire_en;
        tag_t            retire_t;
        tag_t            retire_t_old;
        logic [31:0]     inst;
        logic            halt;
        logic            wr_mem;
        logic            has_dest_reg;
        logic [XLEN-1:0] npc;
        logic            take_branch;
    } rob_ir_packet_t;

    typedef enum logic [1:0] {
        RUN,
        STORE_WAIT,
        RECOVER,
        HALTED
    } retire_state_e;

endpackage

// File: rtl/retire_stage_if.sv
// ROB-head / store-queue / free-list / map-table signals seen by the retire stage.
interface retire_stage_if;
    import retire_stage_pkg::*;

    logic                     retire_en;
    tag_t                     retire_t;
    tag_t                     retire_t_old;
    logic [31:0]              inst;
    logic                     halt;
    logic                     wr_mem;
    logic                     has_dest_reg;
    logic [XLEN-1:0]          NPC;
    logic                     take_branch;
    logic                     sq_commit_ack;

    logic                     ir_stall;
    logic                     sq_commit_req;
    logic                     free_en;
    tag_t                     free_tag;
    logic                     flush;
    logic                     amt_restore_en;
    logic [ARCH_REGS*TW-1:0]  amt_bus;
    logic                     commit_valid;
    logic [XLEN-1:0]          commit_NPC;
    logic [31:0]              retired_count;
    logic                     halted;

    modport master (
        output retire_en, retire_t, retire_t_old, inst, halt, wr_mem, has_dest_reg,
               NPC, take_branch, sq_commit_ack,
        input  ir_stall, sq_commit_req, free_en, free_tag, flush, amt_restore_en,
               amt_bus, commit_valid, commit_NPC, retired_count, halted
    );

    modport slave (
        input  retire_en, retire_t, retire_t_old, inst, halt, wr_mem, has_dest_reg,
               NPC, take_branch, sq_commit_ack,
        output ir_stall, sq_commit_req, free_en, free_tag, flush, amt_restore_en,
               amt_bus, commit_valid, commit_NPC, retired_count, halted
    );

endinterface

// File: rtl/retire_stage_arch_map_table.sv
// Architectural map table: one write port, reset to the identity mapping, flat read bus.
module arch_map_table
    import retire_stage_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  arch_idx_t               wr_idx,
    input  tag_t                    wr_tag,
    output logic [ARCH_REGS*TW-1:0] amt_bus
);

    tag_t amt_q [ARCH_REGS];
    tag_t amt_d [ARCH_REGS];

    always_comb begin
        amt_d = amt_q;
        if (wr_en) begin
            amt_d[wr_idx] = wr_tag;
        end
    end

    // NOTE: this storage is reset on purpose -- the identity mapping is architectural
    // state after reset, unlike a plain data RAM which would be left unreset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                amt_q[i] <= tag_t'(i);
            end
        end else begin
            amt_q <= amt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < ARCH_REGS; i++) begin
            amt_bus[i*TW +: TW] = amt_q[i];
        end
    end

endmodule

// File: rtl/retire_stage.sv
// In-order retire stage: commits the ROB head, updates the AMT, frees stale tags,
// sequences store commit, triggers branch recovery and latches halt.
module retire_stage
    import retire_stage_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    retire_stage_if.slave bus
);

    rob_ir_packet_t head;
    retire_state_e  state_q, state_d;
    logic [31:0]    retired_count_q, retired_count_d;
    logic           ir_stall, sq_commit_req, flush, amt_restore_en;
    logic           commit, amt_we;
    arch_idx_t      rd;
    logic           unused_inst_bits;

    always_comb begin
        head = '{retire_en:    bus.retire_en,
                 retire_t:     bus.retire_t,
                 retire_t_old: bus.retire_t_old,
                 inst:         bus.inst,
                 halt:         bus.halt,
                 wr_mem:       bus.wr_mem,
                 has_dest_reg: bus.has_dest_reg,
                 npc:          bus.NPC,
                 take_branch:  bus.take_branch};
    end

    assign rd               = head.inst[11:7];
    assign unused_inst_bits = ^{head.inst[31:12], head.inst[6:0]};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path through the
        // case can leave one unassigned and infer a latch.
        state_d        = state_q;
        ir_stall       = 1'b0;
        sq_commit_req  = 1'b0;
        flush          = 1'b0;
        amt_restore_en = 1'b0;
        case (state_q)
            RUN: begin
                if (head.retire_en) begin
                    if (head.wr_mem) begin
                        // Ack in this request cycle is deliberately not looked at.
                        ir_stall      = 1'b1;
                        sq_commit_req = 1'b1;
                        state_d       = STORE_WAIT;
                    end else if (head.halt) begin
                        state_d = HALTED;
                    end else if (head.take_branch) begin
                        flush   = 1'b1;
                        state_d = RECOVER;
                    end
                end
            end
            STORE_WAIT: begin
                sq_commit_req = !bus.sq_commit_ack;
                ir_stall      = !bus.sq_commit_ack;
                if (bus.sq_commit_ack) begin
                    state_d = RUN;
                end
            end
            RECOVER: begin
                ir_stall       = 1'b1;
                amt_restore_en = 1'b1;
                state_d        = RUN;
            end
            HALTED: begin
                ir_stall = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // A reset cycle abandons whatever is in flight: nothing commits and nothing is freed.
    assign commit          = head.retire_en && !ir_stall && !reset;
    assign amt_we          = commit && head.has_dest_reg && (rd != '0);
    assign retired_count_d = retired_count_q + 32'(commit);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= RUN;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            retired_count_q <= retired_count_d;
        end
    end

    arch_map_table u_amt (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (amt_we),
        .wr_idx  (rd),
        .wr_tag  (head.retire_t),
        .amt_bus (bus.amt_bus)
    );

    assign bus.ir_stall       = ir_stall;
    assign bus.sq_commit_req  = sq_commit_req;
    assign bus.free_en        = amt_we;
    assign bus.free_tag       = head.retire_t_old;
    assign bus.flush          = flush;
    assign bus.amt_restore_en = amt_restore_en;
    assign bus.commit_valid   = commit;
    assign bus.commit_NPC     = head.npc;
    assign bus.retired_count  = retired_count_q;
    assign bus.halted         = (state_q == HALTED);

    a_store_exclusive: assert property (@(posedge clock) disable iff (reset)
        head.retire_en |-> !(head.wr_mem && (head.halt || head.take_branch)));

endmodule

// File: tb/tb_retire_stage.sv
// Scoreboard bench for retire_stage: directed scenarios followed by random ROB-head traffic.
module tb_retire_stage;
    import retire_stage_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    retire_stage_if bus();

    retire_stage dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit        retire_en;
        bit [5:0]  t;
        bit [5:0]  t_old;
        bit [31:0] inst;
        bit        halt;
        bit        wr_mem;
        bit        has_dest;
        bit        take_branch;
        bit [31:0] npc;
    } head_t;

    typedef struct {
        bit         in_reset;
        bit         ir_stall;
        bit         sq_req;
        bit         free_en;
        bit [5:0]   free_tag;
        bit         flush;
        bit         restore;
        bit         commit_valid;
        bit         halted;
        bit [31:0]  count;
        bit [191:0] amt;
    } exp_t;

    exp_t      exp_q[$];
    bit [31:0] npc_q[$];
    int        checks = 0;
    int        errors = 0;

    // Reference model: architectural view of what retire has done so far.
    bit [5:0]  m_amt [32];
    bit [31:0] m_count;
    bit        m_store_pending;
    bit        m_recovering;
    bit        m_halted;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_amt[i] = 6'(i);
        m_count         = 0;
        m_store_pending = 0;
        m_recovering    = 0;
        m_halted        = 0;
    endfunction

    function automatic head_t mk(input bit en, input bit [4:0] rd, input bit [5:0] t,
                                 input bit [5:0] t_old, input bit dest, input bit st,
                                 input bit hl, input bit br);
        head_t h;
        h.retire_en   = en;
        h.inst        = $urandom;
        h.inst[11:7]  = rd;
        h.t           = t;
        h.t_old       = t_old;
        h.has_dest    = dest;
        h.wr_mem      = st;
        h.halt        = hl;
        h.take_branch = br;
        h.npc         = $urandom;
        return h;
    endfunction

    function automatic head_t rand_head();
        int    kind = $urandom_range(0, 99);
        head_t h;
        h = mk($urandom_range(0, 9) < 7, 5'($urandom), 6'($urandom), 6'($urandom),
               $urandom_range(0, 3) != 0, kind < 15, kind >= 15 && kind < 20,
               kind >= 18 && kind < 35);
        if ($urandom_range(0, 9) == 0) h.inst[11:7] = 5'd0;
        return h;
    endfunction

    // Apply one cycle of stimulus, predict this cycle's outputs, advance to the next cycle.
    task automatic step(input head_t h, input bit ack, input bit rst, output bit stalled);
        exp_t e;
        bit   commit = 0;
        bus.retire_en     = h.retire_en;
        bus.retire_t      = h.t;
        bus.retire_t_old  = h.t_old;
        bus.inst          = h.inst;
        bus.halt          = h.halt;
        bus.wr_mem        = h.wr_mem;
        bus.has_dest_reg  = h.has_dest;
        bus.NPC           = h.npc;
        bus.take_branch   = h.take_branch;
        bus.sq_commit_ack = ack;
        reset             = rst;

        e = '{default: 0};
        e.count  = m_count;
        e.halted = m_halted;
        for (int i = 0; i < 32; i++) e.amt[i*6 +: 6] = m_amt[i];

        if (rst) begin
            e.in_reset = 1;
        end else if (m_halted) begin
            e.ir_stall = 1;
        end else if (m_recovering) begin
            e.ir_stall     = 1;
            e.restore      = 1;
            m_recovering   = 0;
        end else if (m_store_pending) begin
            e.sq_req   = !ack;
            e.ir_stall = !ack;
            if (ack) begin
                m_store_pending = 0;
                commit          = h.retire_en;
            end
        end else if (h.retire_en) begin
            if (h.wr_mem) begin
                e.ir_stall      = 1;
                e.sq_req        = 1;
                m_store_pending = 1;
            end else begin
                commit = 1;
                if (h.halt) m_halted = 1;
                else if (h.take_branch) begin
                    e.flush      = 1;
                    m_recovering = 1;
                end
            end
        end

        if (commit) begin
            e.commit_valid = 1;
            npc_q.push_back(h.npc);
            m_count++;
            if (h.has_dest && h.inst[11:7] != 0) begin
                e.free_en           = 1;
                e.free_tag          = h.t_old;
                m_amt[h.inst[11:7]] = h.t;
            end
        end
        if (rst) model_reset();
        exp_q.push_back(e);
        stalled = !rst && e.ir_stall;
        @(posedge clock);
        #1;
    endtask

    // Monitor: per-cycle output scoreboard plus an in-order commit scoreboard.
    initial begin : monitor
        exp_t      e;
        bit [31:0] n;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("commit_valid", bus.commit_valid, e.commit_valid);
                check("free_en", bus.free_en, e.free_en);
                if (!e.in_reset) begin
                    check("ir_stall", bus.ir_stall, e.ir_stall);
                    check("sq_commit_req", bus.sq_commit_req, e.sq_req);
                    check("flush", bus.flush, e.flush);
                    check("amt_restore_en", bus.amt_restore_en, e.restore);
                    check("halted", bus.halted, e.halted);
                    check("retired_count", bus.retired_count, e.count);
                    check("amt_bus", bus.amt_bus, e.amt);
                    if (e.free_en) check("free_tag", bus.free_tag, e.free_tag);
                end
            end
            if (bus.commit_valid === 1'b1) begin
                if (npc_q.size() == 0) begin
                    check("unexpected_commit", 1, 0);
                end else begin
                    n = npc_q.pop_front();
                    check("commit_NPC", bus.commit_NPC, n);
                end
            end
        end
    end

    initial begin : driver
        head_t idle, h, br;
        bit    st;
        bit    hold;
        bit    ack;
        bit    rst;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        bus.retire_en = 0; bus.retire_t = 0; bus.retire_t_old = 0; bus.inst = 0;
        bus.halt = 0; bus.wr_mem = 0; bus.has_dest_reg = 0; bus.NPC = 0;
        bus.take_branch = 0; bus.sq_commit_ack = 0;
        model_reset();
        @(posedge clock);
        #1;
        step(idle, 0, 1, st);
        step(idle, 0, 0, st);

        // rd=5 -> t=40, stale tag 5 freed; then an rd=0 write that must not touch the AMT
        step(mk(1, 5'd5, 6'd40, 6'd5, 1, 0, 0, 0), 0, 0, st);
        step(idle, 0, 0, st);
        step(mk(1, 5'd0, 6'd33, 6'd9, 1, 0, 0, 0), 0, 0, st);
        step(idle, 0, 0, st);

        // Store with an ack in the request cycle (ignored), then ack after 3 wait cycles
        h = mk(1, 5'd0, 0, 0, 0, 1, 0, 0);
        step(h, 1, 0, st);
        step(h, 0, 0, st);
        step(h, 0, 0, st);
        step(h, 0, 0, st);
        step(h, 1, 0, st);
        step(idle, 0, 0, st);

        // rd=3 -> t=50, taken branch, a head presented during recovery is held
        step(mk(1, 5'd3, 6'd50, 6'd3, 1, 0, 0, 0), 0, 0, st);
        step(mk(1, 5'd8, 6'd20, 6'd8, 1, 0, 0, 1), 0, 0, st);
        br = mk(1, 5'd9, 6'd21, 6'd9, 1, 0, 0, 0);
        step(br, 0, 0, st);
        step(br, 0, 0, st);

        // Halt combined with a taken branch: halt wins, stage freezes until reset
        h = mk(1, 5'd4, 6'd22, 6'd4, 1, 0, 1, 1);
        step(h, 0, 0, st);
        h = mk(1, 5'd6, 6'd23, 6'd6, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(h, 1, 0, st);
        step(idle, 0, 1, st);
        step(idle, 0, 0, st);

        // Reset while waiting on the store queue, with ack raised during reset
        h = mk(1, 5'd0, 0, 0, 0, 1, 0, 0);
        step(h, 0, 0, st);
        step(h, 0, 0, st);
        step(h, 1, 1, st);
        step(idle, 0, 0, st);

        hold = 0;
        h    = idle;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) h = rand_head();
            ack = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 7) == 0);
            step(h, ack, rst, st);
            hold = st && h.retire_en;
        end

        bus.retire_en     = 0;
        bus.sq_commit_ack = 0;
        @(negedge clock);
        @(negedge clock);
        check("exp_queue_drained", exp_q.size(), 0);
        check("commit_queue_drained", npc_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/retire_stage.md
Name: retire_stage

Overview:
In-order retire (IR) stage directly downstream of the ROB head. Each cycle it consumes at most one completed ROB head entry. It then updates the architectural map table (AMT) and returns the stale physical tag to the free list. It also sequences store commit, triggers mispredict recovery and latches halt; ROB back-pressure is via ir_stall.

Parameters:
ARCH_REGS, 32, architectural registers; index = inst[11:7] (rd).
PHYS_REGS, 64, physical registers; TAG width TW = $clog2(PHYS_REGS).
XLEN, 32, PC width.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
retire_en  in  1  ROB head is completed and valid
retire_t  in  TW  head's new physical tag
retire_t_old  in  TW  head's previous mapping of rd
inst  in  32  head instruction (rd = inst[11:7])
halt  in  1  head is a halt
wr_mem  in  1  head is a store
has_dest_reg  in  1  head writes rd
NPC  in  XLEN  head's next PC
take_branch  in  1  head is a taken branch (predict-not-taken mispredict)
sq_commit_ack  in  1  store queue finished the oldest store
ir_stall  out  1  combinational; ROB must hold head when 1
sq_commit_req  out  1  request store queue to commit oldest store
free_en  out  1  push free_tag to free list
free_tag  out  TW  tag being freed
flush  out  1  drives ROB/pipeline interrupt (squash)
amt_restore_en  out  1  map table loads amt_bus
amt_bus  out  ARCH_REGS*TW  full AMT contents, entry i at [i*TW +: TW]
commit_valid  out  1  one instruction retired this cycle
commit_NPC  out  XLEN  NPC of retired instruction
retired_count  out  32  total retired instructions
halted  out  1  sticky halt indicator

Behaviour:
- Commit condition: commit = retire_en && !ir_stall. At most one commit per cycle. All commit side-effects are visible on the edge ending the commit cycle.
- Commit actions:
  - commit_valid = 1; commit_NPC = NPC.
  - retired_count += 1 (wraps mod 2^32).
  - If has_dest_reg && rd != 0: AMT[rd] <= retire_t; free_en = 1; free_tag = retire_t_old (combinational, same cycle).
  - rd == 0 or !has_dest_reg: no AMT write; free_en = 0.
- FSM states: RUN, STORE_WAIT, RECOVER, HALTED.
- RUN, !retire_en: all pulse outputs 0, ir_stall = 0.
- RUN, retire_en && wr_mem: ir_stall = 1; sq_commit_req = 1; next state STORE_WAIT; no commit this cycle.
- STORE_WAIT:
  - sq_commit_req held 1; ir_stall = !sq_commit_ack.
  - On ack: the store commits that cycle; sq_commit_req = 0 in the same cycle; next state RUN.
  - Ack arriving in the RUN request cycle is ignored.
- RUN, retire_en && halt && !wr_mem: commit; next HALTED.
- HALTED: ir_stall = 1; halted = 1; all other pulses 0; exits only on reset.
- RUN, retire_en && take_branch: commit normally; flush = 1 same cycle; next RECOVER.
- RECOVER (exactly 1 cycle): ir_stall = 1; amt_restore_en = 1.
  - amt_bus reflects the AMT already updated by the branch commit.
  - retire_en ignored; next RUN.
- Combined flags: take_branch with halt gives priority to halt (no flush). wr_mem never combines with halt or take_branch (assertion).
- amt_bus is continuously driven from the AMT registers.
- Reset:
  - State RUN; AMT[i] = i for all i; retired_count = 0; halted = 0.
  - All pulses 0 the cycle after reset.
  - Reset mid-STORE_WAIT or RECOVER abandons the operation with no commit and no free.
- No protection against double-free; the ROB guarantees unique t_old.

Decomposition:
- Shared package: TAG typedef (TW bits), ROB_IR_PACKET (the retire_* input group plus take_branch), RETIRE_STATE enum, ARCH_REGS/PHYS_REGS constants.
- One sub-module, arch_map_table: AMT registers, write port (en, idx, tag), reset-to-identity, flattened read bus.
- FSM and counters live in retire_stage.

Test Plan:
1. Reset, then retire rd=5, t=40, t_old=5 → same cycle free_en=1, free_tag=5, commit_valid=1; next cycle amt_bus[5]=40, retired_count=1.
2. Retire rd=0, has_dest_reg=1, t=33 → free_en=0; AMT unchanged; retired_count increments.
3. Store at head; sq_commit_ack delayed 3 cycles → ir_stall=1 and sq_commit_req=1 for 4 cycles; commit on the ack cycle; one commit_valid pulse.
4. Taken branch at head after rd=3→t=50 → flush=1 on the commit cycle; next cycle amt_restore_en=1, amt_bus[3]=50, ir_stall=1; then RUN.
5. Halt retires → halted=1 from next cycle; ir_stall=1 thereafter; retired_count frozen; reset returns halted=0 and the identity AMT.
6. Reset asserted during STORE_WAIT → no commit, sq_commit_req=0 next cycle, retired_count=0.
